// File: rtl/axi_rd_slice_pkg.sv
// Shared definitions for the AXI read-path slice: default widths and the
// skid-buffer occupancy encoding.
package axi_rd_slice_pkg;

    localparam int AXI_ID_W_DEF    = 3;
    localparam int AXI_ADDR_W_DEF  = 3;
    localparam int AXI_DATA_W_DEF  = 8;
    localparam int AXI_MAX_OUT_DEF = 4;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axi_rd_slice_if.sv
// AXI read-only bus (AR + R channels). "master" drives AR and accepts R;
// "slave" accepts AR and returns R.
interface axi_rd_slice_if #(
    parameter int ID_W   = axi_rd_slice_pkg::AXI_ID_W_DEF,
    parameter int ADDR_W = axi_rd_slice_pkg::AXI_ADDR_W_DEF,
    parameter int DATA_W = axi_rd_slice_pkg::AXI_DATA_W_DEF
) ();

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic              arvld;
    logic              arrdy;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic              rvld;
    logic              rrdy;

    modport master (
        output arid, araddr, arvld, rrdy,
        input  arrdy, rid, rdata, rvld
    );

    modport slave (
        input  arid, araddr, arvld, rrdy,
        output arrdy, rid, rdata, rvld
    );

endinterface

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer: registered in-ready and out-valid, payload always
// presented from the head register, second register catches the skid beat.
module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i
);
    import axi_rd_slice_pkg::*;

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_rdy_q;
    logic             out_vld_q;
    logic             push;
    logic             pop;

    assign push       = in_vld_i && in_rdy_q;
    assign pop        = out_vld_q && out_rdy_i;
    assign in_rdy_o   = in_rdy_q;
    assign out_vld_o  = out_vld_q;
    assign out_data_o = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                case ({push, pop})
                    2'b11: head_d = in_data_i;
                    2'b10: begin
                        skid_d  = in_data_i;
                        state_d = SKID_FULL;
                    end
                    2'b01: state_d = SKID_EMPTY;
                    default: ;
                endcase
            end
            SKID_FULL: begin
                // in_rdy is low here, so only a pop can happen
                if (pop) begin
                    head_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SKID_EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            in_rdy_q  <= (state_d != SKID_FULL);
            out_vld_q <= (state_d != SKID_EMPTY);
        end
    end

endmodule

// File: rtl/axi_rd_slice.sv
// Registered AXI read-path bridge: skid-buffered AR and R channels, a cap on
// reads in flight, and detection/dropping of R beats nobody asked for.
module axi_rd_slice #(
    parameter int  ID_W    = axi_rd_slice_pkg::AXI_ID_W_DEF,
    parameter int  ADDR_W  = axi_rd_slice_pkg::AXI_ADDR_W_DEF,
    parameter int  DATA_W  = axi_rd_slice_pkg::AXI_DATA_W_DEF,
    parameter int  MAX_OUT = axi_rd_slice_pkg::AXI_MAX_OUT_DEF,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_rd_slice_if.slave    m,
    axi_rd_slice_if.master   s,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_unexp
);

    localparam int AR_W = ID_W + ADDR_W;
    localparam int R_W  = ID_W + DATA_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             err_q;

    logic [AR_W-1:0]  ar_out_data;
    logic             ar_out_vld;
    logic             ar_out_rdy;
    logic [R_W-1:0]   r_out_data;
    logic             r_out_vld;
    logic             r_in_vld;
    logic             r_in_rdy;

    logic             room;
    logic             ar_hs;
    logic             s_r_hs;
    logic             m_r_hs;
    logic             unexp;
    logic             r_exp_hs;

    axi_skid_buf #(.WIDTH(AR_W)) u_ar_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  ({m.arid, m.araddr}),
        .in_vld_i   (m.arvld),
        .in_rdy_o   (m.arrdy),
        .out_data_o (ar_out_data),
        .out_vld_o  (ar_out_vld),
        .out_rdy_i  (ar_out_rdy)
    );

    axi_skid_buf #(.WIDTH(R_W)) u_r_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  ({s.rid, s.rdata}),
        .in_vld_i   (r_in_vld),
        .in_rdy_o   (r_in_rdy),
        .out_data_o (r_out_data),
        .out_vld_o  (r_out_vld),
        .out_rdy_i  (m.rrdy)
    );

    // AR leaves the buffer only while the in-flight cap has room
    assign room                 = (total_q < MAX_CNT);
    assign s.arvld              = ar_out_vld && room;
    assign ar_out_rdy           = room && s.arrdy;
    assign {s.arid, s.araddr}   = ar_out_data;

    assign ar_hs    = s.arvld && s.arrdy;
    assign s_r_hs   = s.rvld && r_in_rdy;
    assign unexp    = s_r_hs && (pend_q == '0) && !ar_hs;
    assign r_exp_hs = s_r_hs && !unexp;
    assign r_in_vld = s.rvld && !unexp;
    assign s.rrdy   = r_in_rdy;

    assign m.rvld             = r_out_vld;
    assign {m.rid, m.rdata}   = r_out_data;
    assign m_r_hs             = r_out_vld && m.rrdy;

    assign outstanding = total_q;
    assign err_unexp   = err_q;

    always_comb begin
        total_d = total_q;
        case ({ar_hs, m_r_hs})
            2'b10:   total_d = total_q + CNT_ONE;
            2'b01:   total_d = total_q - CNT_ONE;
            default: ;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        case ({ar_hs, r_exp_hs})
            2'b10:   pend_d = pend_q + CNT_ONE;
            2'b01:   pend_d = pend_q - CNT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            pend_q  <= pend_d;
            err_q   <= unexp;
        end
    end

endmodule

// File: tb/tb_axi_rd_slice.sv
// Bench for axi_rd_slice: directed scenarios, then randomized traffic checked
// against a queue-based model of what each port is owed.
module tb_axi_rd_slice;

    localparam int ID_W    = 3;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } ar_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } r_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CNT_W-1:0] outstanding;
    logic err_unexp;

    always #5 clk = ~clk;

    axi_rd_slice_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();
    axi_rd_slice_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    axi_rd_slice #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m           (m_bus),
        .s           (s_bus),
        .outstanding (outstanding),
        .err_unexp   (err_unexp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: what each side is still owed
    ar_t               ar_q[$];
    logic [ID_W-1:0]   sl_q[$];
    r_t                r_q[$];
    int                tot;
    bit                exp_err;
    bit                unexp_cur;
    bit                m_ar_took, s_r_took;
    bit                m_hold, s_hold;
    r_t                m_held;
    ar_t               s_held;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_bus.arvld  = 1'b0;
        m_bus.arid   = '0;
        m_bus.araddr = '0;
        m_bus.rrdy   = 1'b0;
        s_bus.arrdy  = 1'b0;
        s_bus.rid    = '0;
        s_bus.rdata  = '0;
        s_bus.rvld   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_cycles(input int n, input int p_ar, input int p_arrdy,
                              input int p_rv, input int p_mrrdy, input int p_un);
        ar_t a;
        r_t  r;
        bit  s_ar_took, m_r_took;
        for (int c = 0; c < n; c++) begin
            check_val("outstanding", outstanding, tot);
            check_val("err_unexp", err_unexp, exp_err);
            if (tot == MAX_OUT) check_val("ar_gated_at_cap", s_bus.arvld, 0);
            if (r_q.size() == 0) check_val("m_rvld_nothing_owed", m_bus.rvld, 0);
            if (ar_q.size() == 0) check_val("s_arvld_nothing_owed", s_bus.arvld, 0);
            if (m_hold) begin
                check_val("m_rvld_hold", m_bus.rvld, 1);
                check_val("m_r_payload_hold", {m_bus.rid, m_bus.rdata}, m_held);
            end
            if (s_hold) begin
                check_val("s_arvld_hold", s_bus.arvld, 1);
                check_val("s_ar_payload_hold", {s_bus.arid, s_bus.araddr}, s_held);
            end
            exp_err = 1'b0;

            if (!m_bus.arvld || m_ar_took) begin
                m_bus.arvld  = ($urandom_range(0, 99) < p_ar);
                m_bus.arid   = ID_W'($urandom);
                m_bus.araddr = ADDR_W'($urandom);
            end
            m_bus.rrdy = ($urandom_range(0, 99) < p_mrrdy);
            if (!s_bus.rvld || s_r_took) begin
                unexp_cur  = 1'b0;
                s_bus.rvld = 1'b0;
                if (sl_q.size() > 0 && $urandom_range(0, 99) < p_rv) begin
                    s_bus.rvld  = 1'b1;
                    s_bus.rid   = sl_q[0];
                    s_bus.rdata = DATA_W'($urandom);
                end else if (sl_q.size() == 0 && $urandom_range(0, 99) < p_un) begin
                    s_bus.rvld  = 1'b1;
                    unexp_cur   = 1'b1;
                    s_bus.rid   = ID_W'($urandom);
                    s_bus.rdata = DATA_W'($urandom);
                end
            end
            // a stray beat must not coincide with an AR that would make it legitimate
            s_bus.arrdy = unexp_cur ? 1'b0 : ($urandom_range(0, 99) < p_arrdy);

            m_ar_took = m_bus.arvld && m_bus.arrdy;
            s_ar_took = s_bus.arvld && s_bus.arrdy;
            s_r_took  = s_bus.rvld && s_bus.rrdy;
            m_r_took  = m_bus.rvld && m_bus.rrdy;

            if (s_ar_took) begin
                check_val("s_ar_owed", ar_q.size() > 0, 1);
                if (ar_q.size() > 0) begin
                    a = ar_q.pop_front();
                    check_val("s_ar_payload", {s_bus.arid, s_bus.araddr}, a);
                    sl_q.push_back(a.id);
                    tot++;
                end
            end
            if (m_ar_took) ar_q.push_back({m_bus.arid, m_bus.araddr});
            if (s_r_took) begin
                if (unexp_cur) exp_err = 1'b1;
                else begin
                    void'(sl_q.pop_front());
                    r_q.push_back({s_bus.rid, s_bus.rdata});
                end
            end
            if (m_r_took) begin
                check_val("m_r_owed", r_q.size() > 0, 1);
                if (r_q.size() > 0) begin
                    r = r_q.pop_front();
                    check_val("m_r_payload", {m_bus.rid, m_bus.rdata}, r);
                    tot--;
                end
            end
            m_hold = m_bus.rvld && !m_bus.rrdy;
            m_held = {m_bus.rid, m_bus.rdata};
            s_hold = s_bus.arvld && !s_bus.arrdy;
            s_held = {s_bus.arid, s_bus.araddr};
            step();
        end
    endtask

    initial begin
        idle_inputs();
        step();
        step();
        // reset state
        check_val("rst_m_arrdy", m_bus.arrdy, 0);
        check_val("rst_s_rrdy", s_bus.rrdy, 0);
        check_val("rst_s_arvld", s_bus.arvld, 0);
        check_val("rst_m_rvld", m_bus.rvld, 0);
        check_val("rst_outstanding", outstanding, 0);
        check_val("rst_err", err_unexp, 0);
        rst_n = 1'b1;
        step();
        check_val("rel_m_arrdy", m_bus.arrdy, 1);
        check_val("rel_s_rrdy", s_bus.rrdy, 1);

        // single read, one-cycle latency each way
        m_bus.arvld = 1'b1; m_bus.arid = 3'd1; m_bus.araddr = 3'd5; s_bus.arrdy = 1'b1;
        step();
        m_bus.arvld = 1'b0;
        check_val("ar_lat_vld", s_bus.arvld, 1);
        check_val("ar_lat_id", s_bus.arid, 1);
        check_val("ar_lat_addr", s_bus.araddr, 5);
        step();
        check_val("ar_out1", outstanding, 1);
        check_val("ar_drained", s_bus.arvld, 0);
        s_bus.rvld = 1'b1; s_bus.rid = 3'd1; s_bus.rdata = 8'hA5; m_bus.rrdy = 1'b1;
        step();
        s_bus.rvld = 1'b0;
        check_val("r_lat_vld", m_bus.rvld, 1);
        check_val("r_lat_id", m_bus.rid, 1);
        check_val("r_lat_data", m_bus.rdata, 8'hA5);
        step();
        check_val("r_done_vld", m_bus.rvld, 0);
        check_val("r_done_out", outstanding, 0);

        // in-flight cap
        do_reset();
        s_bus.arrdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m_bus.arvld = 1'b1; m_bus.arid = ID_W'(i); m_bus.araddr = ADDR_W'(i);
            step();
        end
        m_bus.arvld = 1'b0;
        step();
        step();
        check_val("cap_out", outstanding, MAX_OUT);
        check_val("cap_arvld", s_bus.arvld, 0);
        check_val("cap_head_addr", s_bus.araddr, 4);
        s_bus.rvld = 1'b1; s_bus.rid = 3'd0; s_bus.rdata = 8'h11; m_bus.rrdy = 1'b1;
        step();
        s_bus.rvld = 1'b0;
        check_val("cap_r_vld", m_bus.rvld, 1);
        step();
        check_val("cap_release_out", outstanding, 3);
        check_val("cap_release_arvld", s_bus.arvld, 1);
        step();
        check_val("cap_refill_out", outstanding, MAX_OUT);
        check_val("cap_refill_arvld", s_bus.arvld, 0);

        // unexpected beat
        do_reset();
        s_bus.rvld = 1'b1; s_bus.rid = 3'd2; s_bus.rdata = 8'h3C; m_bus.rrdy = 1'b1;
        step();
        s_bus.rvld = 1'b0;
        check_val("unexp_pulse", err_unexp, 1);
        check_val("unexp_no_rvld", m_bus.rvld, 0);
        step();
        check_val("unexp_pulse_end", err_unexp, 0);
        check_val("unexp_no_rvld2", m_bus.rvld, 0);
        check_val("unexp_out", outstanding, 0);

        // reset in the middle of traffic
        do_reset();
        s_bus.arrdy = 1'b1;
        m_bus.arvld = 1'b1; m_bus.arid = 3'd0; m_bus.araddr = 3'd1;
        step();
        m_bus.arid = 3'd1; m_bus.araddr = 3'd2;
        step();
        m_bus.arvld = 1'b0;
        step();
        step();
        check_val("mid_out2", outstanding, 2);
        s_bus.rvld = 1'b1; s_bus.rid = 3'd0; s_bus.rdata = 8'h77; m_bus.rrdy = 1'b0;
        step();
        s_bus.rvld = 1'b0;
        check_val("mid_buffered", m_bus.rvld, 1);
        rst_n = 1'b0;
        step();
        check_val("mid_rst_m_rvld", m_bus.rvld, 0);
        check_val("mid_rst_s_arvld", s_bus.arvld, 0);
        check_val("mid_rst_out", outstanding, 0);
        check_val("mid_rst_m_arrdy", m_bus.arrdy, 0);
        check_val("mid_rst_s_rrdy", s_bus.rrdy, 0);
        rst_n = 1'b1;
        step();
        check_val("mid_rel_m_arrdy", m_bus.arrdy, 1);
        check_val("mid_rel_s_rrdy", s_bus.rrdy, 1);
        check_val("mid_rel_out", outstanding, 0);

        // randomized traffic against the model
        do_reset();
        tot = 0; exp_err = 1'b0; unexp_cur = 1'b0;
        m_ar_took = 1'b0; s_r_took = 1'b0; m_hold = 1'b0; s_hold = 1'b0;
        run_cycles(1500, 60, 70, 60, 70, 10);
        run_cycles(1500, 90, 90, 90, 20, 5);
        run_cycles(1500, 40, 30, 50, 95, 20);
        run_cycles(1500, 95, 100, 100, 100, 5);
        run_cycles(80, 0, 100, 100, 100, 0);
        check_val("drain_ar_q", ar_q.size(), 0);
        check_val("drain_sl_q", sl_q.size(), 0);
        check_val("drain_r_q", r_q.size(), 0);
        check_val("drain_out", outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
